// File: rtl/mcu_spi_if.sv
// mcu_spi_if
// Byte-level handshake between the SPI slave front end and the system
// control block.
//   mcu_strobe : one-clk pulse per completed byte
//   mcu_start  : first byte of a frame, valid only with mcu_strobe
//   mcu_dout   : received byte, valid while mcu_strobe is high
//   mcu_din    : reply byte, sampled on the first sclk falling edge after
//                a byte completes
// Modports:
//   master : the SPI front end (drives strobe/start/dout, reads din)
//   slave  : the system control block (reads strobe/start/dout, drives din)
`timescale 1ns/1ps

interface mcu_spi_if;
    logic       mcu_strobe;
    logic       mcu_start;
    logic [7:0] mcu_dout;
    logic [7:0] mcu_din;

    modport master (
        output mcu_strobe,
        output mcu_start,
        output mcu_dout,
        input  mcu_din
    );

    modport slave (
        input  mcu_strobe,
        input  mcu_start,
        input  mcu_dout,
        output mcu_din
    );
endinterface

// File: rtl/mcu_spi.sv
// mcu_spi
// Mode-0 SPI slave for an external MCU, oversampled on clk. The SPI pins
// are asynchronous to clk; each is synchronized, edges are detected and
// registered, then a small frame FSM assembles received bytes and shifts
// out reply bytes.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   spi_csn       : chip select from MCU, active low (async)
//   spi_sclk      : SPI clock from MCU, mode 0 (async)
//   spi_mosi      : MCU to FPGA data, MSB first (async)
//   spi_miso      : FPGA to MCU data, MSB first, 0 outside a frame
//   mcu           : byte handshake to the system control block (master)
//   frame_active  : high while a frame is open
//   byte_count    : bytes completed in the current frame, saturating at 255
//
// Pipeline from an sclk pin edge to mcu_strobe:
//   2 sync flops -> registered edge pulse -> frame FSM -> output register
// so the strobe rises 4 clk after the first clk edge that samples sclk high.
//
// State table:
//   ST_IDLE  | no frame open; sclk edges are ignored
//   ST_FRAME | frame open; bytes are shifted in and replies shifted out
`timescale 1ns/1ps

module mcu_spi (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    mcu_spi_if.master   mcu,
    output logic        frame_active,
    output logic [7:0]  byte_count
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Synchronizers and edge-detect history.
    logic       csn_s1, csn_s2, csn_d;
    logic       sclk_s1, sclk_s2, sclk_d;
    logic       mosi_s1, mosi_s2;

    // Registered edge pulses, all aligned to the same cycle.
    logic       sclk_rise_q, sclk_fall_q;
    logic       csn_rise_q, csn_fall_q;

    // Post-reset arming of the csn falling-edge detector.
    logic [1:0] settle_cnt;
    logic       csn_armed;

    // Frame FSM state.
    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic       first_byte;
    logic       load_pending;
    logic       byte_done;
    logic       done_first;
    logic       frame_open;

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    // csn resets to 1 in the synchronizer, so if spi_csn is already low
    // when reset releases the chain would show a false falling edge.
    // The falling-edge detector is therefore only armed once the chain
    // has flushed and a genuine high level on csn has been observed;
    // a frame abandoned by reset stays dead until csn goes high and low
    // again.
    always_ff @(posedge clk) begin
        if (reset) begin
            csn_s1      <= 1'b1;
            csn_s2      <= 1'b1;
            csn_d       <= 1'b1;
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_d      <= 1'b0;
            mosi_s1     <= 1'b0;
            mosi_s2     <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            csn_rise_q  <= 1'b0;
            csn_fall_q  <= 1'b0;
            settle_cnt  <= 2'd0;
            csn_armed   <= 1'b0;
        end else begin
            csn_s1      <= spi_csn;
            csn_s2      <= csn_s1;
            csn_d       <= csn_s2;
            sclk_s1     <= spi_sclk;
            sclk_s2     <= sclk_s1;
            sclk_d      <= sclk_s2;
            mosi_s1     <= spi_mosi;
            mosi_s2     <= mosi_s1;

            sclk_rise_q <= sclk_s2 & ~sclk_d;
            sclk_fall_q <= ~sclk_s2 & sclk_d;
            csn_rise_q  <= csn_s2 & ~csn_d;
            csn_fall_q  <= csn_armed & ~csn_s2 & csn_d;

            if (settle_cnt != 2'd3) begin
                settle_cnt <= settle_cnt + 2'd1;
            end else if (csn_s2) begin
                csn_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // A csn rising edge takes priority over any sclk edge seen in the
    // same cycle; a partial byte is simply dropped by clearing bit_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            rx_sr        <= 8'h00;
            tx_sr        <= 8'h00;
            first_byte   <= 1'b0;
            load_pending <= 1'b0;
            byte_done    <= 1'b0;
            done_first   <= 1'b0;
            frame_open   <= 1'b0;
        end else begin
            byte_done  <= 1'b0;
            frame_open <= 1'b0;

            if (csn_rise_q) begin
                state        <= ST_IDLE;
                bit_cnt      <= 3'd0;
                load_pending <= 1'b0;
            end else if (csn_fall_q) begin
                state        <= ST_FRAME;
                bit_cnt      <= 3'd0;
                first_byte   <= 1'b1;
                tx_sr        <= 8'h00;
                load_pending <= 1'b0;
                frame_open   <= 1'b1;
            end else if (state == ST_FRAME) begin
                if (sclk_rise_q) begin
                    rx_sr   <= {rx_sr[6:0], mosi_s2};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done    <= 1'b1;
                        done_first   <= first_byte;
                        first_byte   <= 1'b0;
                        load_pending <= 1'b1;
                    end
                end else if (sclk_fall_q) begin
                    // The reply is captured on the falling edge that ends
                    // the completed byte, so its MSB is on MISO before the
                    // next rising edge.
                    if (load_pending) begin
                        tx_sr        <= mcu.mcu_din;
                        load_pending <= 1'b0;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    // byte_count is updated in the same cycle as mcu_strobe, so it already
    // includes the byte being strobed.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcu.mcu_strobe <= 1'b0;
            mcu.mcu_start  <= 1'b0;
            mcu.mcu_dout   <= 8'h00;
            byte_count     <= 8'h00;
        end else begin
            mcu.mcu_strobe <= byte_done;
            if (byte_done) begin
                mcu.mcu_dout  <= rx_sr;
                mcu.mcu_start <= done_first;
            end
            if (frame_open) begin
                byte_count <= 8'h00;
            end else if (byte_done && (byte_count != 8'hFF)) begin
                byte_count <= byte_count + 8'h01;
            end
        end
    end

    assign frame_active = (state == ST_FRAME);
    assign spi_miso     = frame_active & tx_sr[7];

endmodule

// File: tb/tb_mcu_spi.sv
`timescale 1ns/1ps

module tb_mcu_spi;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_csn = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       frame_active;
    logic [7:0] byte_count;

    mcu_spi_if bus ();

    mcu_spi dut (
        .clk          (clk),
        .reset        (reset),
        .spi_csn      (spi_csn),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .mcu          (bus),
        .frame_active (frame_active),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic [7:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    int   model_bc = 0;
    logic prev_strobe = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Strobe scoreboard: every strobe must match the next queued byte.
    always @(negedge clk) begin
        if (!reset && bus.mcu_strobe) begin
            strobe_cnt++;
            check("strobe_width", prev_strobe, 1'b0);
            check("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mcu_dout", bus.mcu_dout, e.dout);
                check("mcu_start", bus.mcu_start, e.start);
                model_bc = (model_bc < 255) ? model_bc + 1 : 255;
                check("byte_count_at_strobe", byte_count, model_bc);
            end
        end
        prev_strobe = reset ? 1'b0 : bus.mcu_strobe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        model_bc = 0;
        tick(HALF + 1);
    endtask

    task automatic csn_high();
        spi_csn = 1'b1;
        tick(HALF + 1);
    endtask

    // Full byte with strobe-latency and MISO checks; reply is placed on
    // mcu_din after the strobe, before the final falling edge.
    task automatic send_byte(input logic [7:0] tx, input logic [7:0] reply,
                             input logic first, input logic [7:0] exp_miso);
        logic [7:0] got;
        got = 8'h00;
        exp_q.push_back('{first, tx});
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            tick(HALF);
            spi_sclk = 1'b1;
            got[i] = spi_miso;
            if (i == 0) begin
                tick(4);
                check("strobe_not_before_4clk", bus.mcu_strobe, 1'b0);
                tick(1);
                check("strobe_at_4clk", bus.mcu_strobe, 1'b1);
                bus.mcu_din = reply;
                tick(HALF - 5);
            end else begin
                tick(HALF);
            end
            spi_sclk = 1'b0;
        end
        check("miso_byte", got, exp_miso);
    endtask

    task automatic send_bits(input logic [7:0] pat, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = pat[7 - (i % 8)];
            tick(HALF);
            spi_sclk = 1'b1;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", spi_miso, 1'b0);
        check("rst_strobe", bus.mcu_strobe, 1'b0);
        check("rst_start", bus.mcu_start, 1'b0);
        check("rst_frame_active", frame_active, 1'b0);
        check("rst_dout", bus.mcu_dout, 8'h00);
        check("rst_byte_count", byte_count, 8'h00);
    endtask

    initial begin
        int s0;
        logic [7:0] mo;
        logic [7:0] rp;
        logic [7:0] prev_rp;

        bus.mcu_din = 8'h00;
        tick(3);
        check_reset_outputs();
        reset = 1'b0;
        tick(5);

        // Single byte frame.
        s0 = strobe_cnt;
        csn_low();
        check("frame_open", frame_active, 1'b1);
        send_byte(8'hA5, 8'h77, 1'b1, 8'h00);
        csn_high();
        check("single_frame_closed", frame_active, 1'b0);
        check("single_byte_count", byte_count, 8'd1);
        check("single_strobes", strobe_cnt - s0, 1);

        // Three byte frame with replies.
        s0 = strobe_cnt;
        csn_low();
        send_byte(8'h00, 8'h5C, 1'b1, 8'h00);
        send_byte(8'h11, 8'h42, 1'b0, 8'h5C);
        send_byte(8'h22, 8'h00, 1'b0, 8'h42);
        csn_high();
        check("three_byte_count", byte_count, 8'd3);
        check("three_strobes", strobe_cnt - s0, 3);

        // Frame aborted after 5 bits of the second byte.
        s0 = strobe_cnt;
        csn_low();
        send_byte(8'h81, 8'h00, 1'b1, 8'h00);
        send_bits(8'hF0, 5);
        spi_csn = 1'b1;
        tick(4);
        check("abort_frame_inactive_4clk", frame_active, 1'b0);
        tick(HALF);
        check("abort_byte_count_held", byte_count, 8'd1);
        check("abort_strobes", strobe_cnt - s0, 1);
        csn_low();
        send_byte(8'hE7, 8'h00, 1'b1, 8'h00);
        csn_high();

        // sclk with csn high is ignored.
        s0 = strobe_cnt;
        for (int i = 0; i < 16; i++) begin
            spi_sclk = ~spi_sclk;
            tick(HALF);
            if (spi_sclk) check("idle_miso", spi_miso, 1'b0);
        end
        check("idle_frame_active", frame_active, 1'b0);
        check("idle_strobes", strobe_cnt - s0, 0);

        // Reset mid-frame with csn still low.
        s0 = strobe_cnt;
        csn_low();
        send_bits(8'hFF, 3);
        reset = 1'b1;
        tick(3);
        check_reset_outputs();
        reset = 1'b0;
        tick(2);
        send_bits(8'hAA, 8);
        check("post_reset_frame_inactive", frame_active, 1'b0);
        check("post_reset_strobes", strobe_cnt - s0, 0);
        csn_high();
        csn_low();
        send_byte(8'h3C, 8'h00, 1'b1, 8'h00);
        csn_high();
        check("post_reset_byte_count", byte_count, 8'd1);

        // 300 byte frame, byte_count saturation.
        s0 = strobe_cnt;
        prev_rp = 8'h00;
        mo = 8'h00;
        csn_low();
        for (int i = 0; i < 300; i++) begin
            mo = 8'((i * 37 + 5) & 255);
            rp = mo ^ 8'h5A;
            send_byte(mo, rp, (i == 0), (i == 0) ? 8'h00 : prev_rp);
            prev_rp = rp;
        end
        csn_high();
        check("long_strobes", strobe_cnt - s0, 300);
        check("long_byte_count_sat", byte_count, 8'd255);
        check("long_last_dout", bus.mcu_dout, mo);

        tick(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
